// File: rtl/cnn_config_loader.sv
// Configuration sequencer for the CNN top level. It takes one byte-wide
// valid/ready stream and unpacks it into the feature weight, bias and fully
// connected weight memory write ports. When the final chunk has been written,
// it pulses convolution_enable low for one cycle to start an inference.
module cnn_config_loader #(
  parameter int NUM_FEATURES    = 3,
  parameter int KERNEL_SIZE     = 4,
  parameter int FC_CHUNKS       = 27,
  parameter int DATA_WIDTH      = 8,
  parameter int BIAS_DATA_WIDTH = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_cnn,
  input  logic                                       load_start,
  input  logic                                       cfg_valid,
  input  logic signed [DATA_WIDTH-1:0]               cfg_data,
  output logic                                       cfg_ready,
  output logic [16*DATA_WIDTH-1:0]                   feature_weights_input,
  output logic [1:0]                                 feature_writeAddr,
  output logic                                       feature_WrEn,
  output logic [(NUM_FEATURES+1)*BIAS_DATA_WIDTH-1:0] bias_weights_input,
  output logic                                       bias_WrEn,
  output logic [16*DATA_WIDTH-1:0]                   fullyconnected_weights_input,
  output logic [4:0]                                 fullyconnected_writeAddr,
  output logic                                       fullyconnected_WrEn,
  output logic                                       convolution_enable,
  output logic                                       load_busy,
  output logic                                       load_done
);

  localparam int LANES  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BUF_W  = LANES * DATA_WIDTH;
  localparam int WORD_W = 16 * DATA_WIDTH;
  localparam int BIAS_W = (NUM_FEATURES + 1) * BIAS_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    FEAT,
    BIAS,
    FC,
    KICK,
    DONE
  } state_t;

  state_t           state, state_d;
  logic             strobe, strobe_d;
  logic [3:0]       byte_idx;
  logic [4:0]       chunk_idx;
  logic [BUF_W-1:0] lane_buf;
  logic [BUF_W-1:0] chunk_word;
  logic             accept;
  logic             last_byte;
  logic             ready_d;
  logic             busy_d;
  logic             done_d;
  logic             kick_d;

  assign accept     = cfg_valid && cfg_ready;
  assign last_byte  = accept && (byte_idx == 4'(LANES - 1));
  // The final byte goes straight into the output word, so no extra cycle is needed to assemble it.
  assign chunk_word = {cfg_data, lane_buf[BUF_W-DATA_WIDTH-1:0]};

  // Next-state logic for the phase FSM and the STROBE sub-phase.
  always_comb begin
    state_d  = state;
    strobe_d = strobe;
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    kick_d   = 1'b0;
    case (state)
      IDLE, DONE: if (load_start) state_d = FEAT;
      FEAT:       if (strobe && chunk_idx == 5'(NUM_FEATURES - 1)) state_d = BIAS;
      BIAS:       if (strobe) state_d = FC;
      FC:         if (strobe && chunk_idx == 5'(FC_CHUNKS - 1)) state_d = KICK;
      KICK:       state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (strobe) strobe_d = 1'b0;
    else if (last_byte) strobe_d = 1'b1;
    ready_d = (state_d == FEAT || state_d == BIAS || state_d == FC) && !strobe_d;
    busy_d  = (state_d == FEAT || state_d == BIAS || state_d == FC || state_d == KICK);
    done_d  = (state_d == DONE);
    kick_d  = (state_d == KICK);
  end

  // Registers for the phase state and the STROBE flag.
  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      state  <= IDLE;
      strobe <= 1'b0;
    end else begin
      state  <= state_d;
      strobe <= strobe_d;
    end
  end

  // Registered control outputs. The strobes are raised together with the STROBE flag.
  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      cfg_ready           <= 1'b0;
      feature_WrEn        <= 1'b1;
      bias_WrEn           <= 1'b1;
      fullyconnected_WrEn <= 1'b1;
      convolution_enable  <= 1'b1;
      load_busy           <= 1'b0;
      load_done           <= 1'b0;
    end else begin
      cfg_ready           <= ready_d;
      feature_WrEn        <= !(last_byte && state == FEAT);
      bias_WrEn           <= !(last_byte && state == BIAS);
      fullyconnected_WrEn <= !(last_byte && state == FC);
      convolution_enable  <= !kick_d;
      load_busy           <= busy_d;
      load_done           <= done_d;
    end
  end

  // Byte lane capture, chunk counting, and the data/address registers for each memory.
  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      byte_idx                     <= '0;
      chunk_idx                    <= '0;
      lane_buf                     <= '0;
      feature_weights_input        <= '0;
      feature_writeAddr            <= '0;
      bias_weights_input           <= '0;
      fullyconnected_weights_input <= '0;
      fullyconnected_writeAddr     <= '0;
    end else begin
      if (accept) begin
        byte_idx <= last_byte ? '0 : byte_idx + 4'd1;
        for (int unsigned k = 0; k < LANES; k++) begin
          if (byte_idx == 4'(k)) lane_buf[k*DATA_WIDTH +: DATA_WIDTH] <= cfg_data;
        end
      end
      if (last_byte) begin
        case (state)
          FEAT: begin
            feature_weights_input <= WORD_W'(chunk_word);
            feature_writeAddr     <= chunk_idx[1:0];
          end
          BIAS: bias_weights_input <= BIAS_W'(chunk_word);
          FC: begin
            fullyconnected_weights_input <= WORD_W'(chunk_word);
            fullyconnected_writeAddr     <= chunk_idx;
          end
          default: ;
        endcase
      end
      if (strobe) chunk_idx <= (state_d == state) ? chunk_idx + 5'd1 : '0;
    end
  end

endmodule
